// File: rtl/des_encrypt_iter.sv
// Iterative DES encryption core, one Feistel round per clock.
// Ports: clk, rst (sync, active-high), in_valid/in_ready/in_data/key,
//        out_valid/out_ready/out_data, busy, key_err.
// Optional key parity flag: define DES_KEY_PARITY_CHECK_EN.
module des_encrypt_iter #(
    parameter int ROUNDS = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_data,
    input  logic [63:0] key,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_data,
    output logic        busy,
    output logic        key_err
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam int IP_T [64] = '{
        58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17, 9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};

    localparam int FP_T [64] = '{
        40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
        38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
        36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
        34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41, 9, 49, 17, 57, 25};

    localparam int PC1_T [56] = '{
        57, 49, 41, 33, 25, 17, 9, 1, 58, 50, 42, 34, 26, 18,
        10, 2, 59, 51, 43, 35, 27, 19, 11, 3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15, 7, 62, 54, 46, 38, 30, 22,
        14, 6, 61, 53, 45, 37, 29, 21, 13, 5, 28, 20, 12, 4};

    localparam int PC2_T [48] = '{
        14, 17, 11, 24, 1, 5, 3, 28, 15, 6, 21, 10, 23, 19, 12, 4,
        26, 8, 16, 7, 27, 20, 13, 2, 41, 52, 31, 37, 47, 55, 30, 40,
        51, 45, 33, 48, 44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

    localparam int E_T [48] = '{
        32, 1, 2, 3, 4, 5, 4, 5, 6, 7, 8, 9, 8, 9, 10, 11,
        12, 13, 12, 13, 14, 15, 16, 17, 16, 17, 18, 19, 20, 21, 20, 21,
        22, 23, 24, 25, 24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32, 1};

    localparam int P_T [32] = '{
        16, 7, 20, 21, 29, 12, 28, 17, 1, 15, 23, 26, 5, 18, 31, 10,
        2, 8, 24, 14, 32, 27, 3, 9, 19, 13, 30, 6, 22, 11, 4, 25};

    // Entry 0 of each box sits in the top nibble; row-major, 16 per row.
    localparam logic [255:0] SBOX [8] = '{
        256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
        256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
        256'hA09E63F51DC7B428_D7093462A85ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
        256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
        256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
        256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
        256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
        256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B};

    // Permutations: table entry n selects DES bit n, i.e. vector bit W-n.
    function automatic logic [63:0] ip_fn(input logic [63:0] x);
        ip_fn = '0;
        for (int i = 0; i < 64; i++)
            ip_fn = {ip_fn[62:0], x[6'(64 - IP_T[i])]};
    endfunction

    function automatic logic [63:0] fp_fn(input logic [63:0] x);
        fp_fn = '0;
        for (int i = 0; i < 64; i++)
            fp_fn = {fp_fn[62:0], x[6'(64 - FP_T[i])]};
    endfunction

    function automatic logic [55:0] pc1_fn(input logic [63:0] x);
        pc1_fn = '0;
        for (int i = 0; i < 56; i++)
            pc1_fn = {pc1_fn[54:0], x[6'(64 - PC1_T[i])]};
    endfunction

    function automatic logic [47:0] pc2_fn(input logic [55:0] x);
        pc2_fn = '0;
        for (int i = 0; i < 48; i++)
            pc2_fn = {pc2_fn[46:0], x[6'(56 - PC2_T[i])]};
    endfunction

    function automatic logic [47:0] e_fn(input logic [31:0] x);
        e_fn = '0;
        for (int i = 0; i < 48; i++)
            e_fn = {e_fn[46:0], x[5'(32 - E_T[i])]};
    endfunction

    function automatic logic [31:0] p_fn(input logic [31:0] x);
        p_fn = '0;
        for (int i = 0; i < 32; i++)
            p_fn = {p_fn[30:0], x[5'(32 - P_T[i])]};
    endfunction

    function automatic logic [31:0] f_fn(
        input logic [31:0] rr,
        input logic [47:0] kk
    );
        logic [47:0] x;
        logic [5:0]  six;
        logic [31:0] s;
        x = e_fn(rr) ^ kk;
        s = '0;
        for (int i = 0; i < 8; i++) begin
            six = x[47:42];
            x   = {x[41:0], 6'd0};
            // Row is outer bits, column inner four; ~idx maps to MSB-first nibble.
            s = {s[27:0], SBOX[i][{~{six[5], six[0], six[4:1]}, 2'b11} -: 4]};
        end
        return p_fn(s);
    endfunction

    state_t      state;
    logic [3:0]  rnd;
    logic [31:0] l, r;
    logic [27:0] c, d;

    logic        one_bit;
    logic [27:0] c_rot, d_rot;
    logic [31:0] r_next;
    logic        accept;

    assign accept = in_valid && in_ready;

    always_comb begin
        one_bit = (rnd == 4'd0) || (rnd == 4'd1) ||
                  (rnd == 4'd8) || (rnd == 4'd15);
        c_rot   = one_bit ? {c[26:0], c[27]} : {c[25:0], c[27:26]};
        d_rot   = one_bit ? {d[26:0], d[27]} : {d[25:0], d[27:26]};
        r_next  = l ^ f_fn(r, pc2_fn({c_rot, d_rot}));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            out_data  <= '0;
            rnd       <= '0;
            l         <= '0;
            r         <= '0;
            c         <= '0;
            d         <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        {l, r}   <= ip_fn(in_data);
                        {c, d}   <= pc1_fn(key);
                        rnd      <= '0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    l <= r;
                    r <= r_next;
                    c <= c_rot;
                    d <= d_rot;
                    if (rnd == 4'(ROUNDS - 1)) begin
                        // Final swap: output block is {R16, L16}.
                        out_data  <= fp_fn({r_next, r});
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        rnd <= rnd + 4'd1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        rnd       <= '0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef DES_KEY_PARITY_CHECK_EN
    function automatic logic par_err(input logic [63:0] k);
        par_err = 1'b0;
        for (int i = 0; i < 8; i++)
            par_err = par_err | ~(^8'(k >> (8 * i)));
    endfunction

    always_ff @(posedge clk) begin
        if (rst)
            key_err <= 1'b0;
        else if (state == IDLE && accept)
            key_err <= par_err(key);
    end
`else
    // Parity bits are dropped by PC-1 and not otherwise inspected.
    logic unused_key;
    assign unused_key = ^{key[56], key[48], key[40], key[32],
                          key[24], key[16], key[8], key[0]};
    assign key_err = 1'b0;
`endif

endmodule

// File: tb/tb_des_encrypt_iter.sv
// Self-checking bench for des_encrypt_iter: reference DES model,
// per-cycle output compare, and directed FIPS vectors.
module tb_des_encrypt_iter;

`ifdef DES_KEY_PARITY_CHECK_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    localparam logic [63:0] K1 = 64'h133457799BBCDFF1;
    localparam logic [63:0] P1 = 64'h0123456789ABCDEF;
    localparam logic [63:0] C1 = 64'h85E813540F0AB405;
    localparam logic [63:0] K2 = 64'h0E329232EA6D0D73;
    localparam logic [63:0] P2 = 64'h8787878787878787;
    localparam logic [63:0] C2 = 64'h0000000000000000;
    localparam logic [63:0] K1_BAD = 64'h133457799BBCDFF0;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [63:0] in_data = '0;
    logic [63:0] key = '0;
    logic        in_ready, out_valid, busy, key_err;
    logic [63:0] out_data;

    des_encrypt_iter dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .key(key),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .busy(busy),
        .key_err(key_err)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    bit started = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // ---------------- reference model (DES-bit-numbered tables) -------------
    int IP_Q[$] = '{58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
                    62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
                    57, 49, 41, 33, 25, 17, 9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
                    61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};
    int PC1_Q[$] = '{57, 49, 41, 33, 25, 17, 9, 1, 58, 50, 42, 34, 26, 18,
                     10, 2, 59, 51, 43, 35, 27, 19, 11, 3, 60, 52, 44, 36,
                     63, 55, 47, 39, 31, 23, 15, 7, 62, 54, 46, 38, 30, 22,
                     14, 6, 61, 53, 45, 37, 29, 21, 13, 5, 28, 20, 12, 4};
    int PC2_Q[$] = '{14, 17, 11, 24, 1, 5, 3, 28, 15, 6, 21, 10, 23, 19, 12, 4,
                     26, 8, 16, 7, 27, 20, 13, 2, 41, 52, 31, 37, 47, 55, 30, 40,
                     51, 45, 33, 48, 44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
    int P_Q[$] = '{16, 7, 20, 21, 29, 12, 28, 17, 1, 15, 23, 26, 5, 18, 31, 10,
                   2, 8, 24, 14, 32, 27, 3, 9, 19, 13, 30, 6, 22, 11, 4, 25};
    int SHIFTS[16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
    int E_Q[$];
    int FP_Q[$];

    logic [255:0] SB[8] = '{
        256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
        256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
        256'hA09E63F51DC7B428_D7093462A85ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
        256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
        256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
        256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
        256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
        256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B};

    function automatic void build_tables();
        int inv[64];
        int s;
        E_Q.delete();
        FP_Q.delete();
        // Expansion: each 6-bit group spans 4 fresh bits plus both neighbours.
        for (int j = 1; j <= 48; j++) begin
            s = 4 * ((j - 1) / 6) + ((j - 1) % 6);
            if (s == 0) s = 32;
            if (s == 33) s = 1;
            E_Q.push_back(s);
        end
        // Final permutation is the inverse of the initial one.
        for (int i = 0; i < 64; i++) inv[IP_Q[i] - 1] = i + 1;
        for (int i = 0; i < 64; i++) FP_Q.push_back(inv[i]);
    endfunction

    function automatic logic [63:0] perm(input logic [63:0] x, input int win,
                                         input int t[$]);
        logic [63:0] o;
        o = '0;
        foreach (t[i]) o = (o << 1) | ((x >> (win - t[i])) & 64'd1);
        return o;
    endfunction

    function automatic logic [63:0] des_ref(input logic [63:0] pt,
                                            input logic [63:0] k);
        logic [63:0] t;
        logic [27:0] c, d;
        logic [47:0] sk[16];
        logic [47:0] x;
        logic [31:0] l, r, f, tmp;
        int sh, six, row, col;
        t = perm(k, 64, PC1_Q);
        c = t[55:28];
        d = t[27:0];
        for (int i = 0; i < 16; i++) begin
            sh = SHIFTS[i];
            c = (c << sh) | (c >> (28 - sh));
            d = (d << sh) | (d >> (28 - sh));
            t = perm({8'h0, c, d}, 56, PC2_Q);
            sk[i] = t[47:0];
        end
        t = perm(pt, 64, IP_Q);
        l = t[63:32];
        r = t[31:0];
        for (int i = 0; i < 16; i++) begin
            t = perm({32'h0, r}, 32, E_Q);
            x = t[47:0] ^ sk[i];
            f = '0;
            for (int b = 0; b < 8; b++) begin
                six = int'((x >> (42 - 6 * b)) & 48'd63);
                row = ((six >> 4) & 2) | (six & 1);
                col = (six >> 1) & 15;
                t = 64'((SB[b] >> (4 * (63 - (row * 16 + col)))) & 256'd15);
                f = (f << 4) | t[31:0];
            end
            t = perm({32'h0, f}, 32, P_Q);
            tmp = r;
            r = l ^ t[31:0];
            l = tmp;
        end
        return perm({r, l}, 64, FP_Q);
    endfunction

    function automatic bit key_bad(input logic [63:0] k);
        bit bad = 0;
        for (int i = 0; i < 8; i++)
            if (^(k >> (8 * i) & 64'hFF) == 1'b0) bad = 1;
        return bad;
    endfunction

    // ---------------- cycle model: pending countdown + held result ----------
    int          m_left = 0;
    bit          m_ov = 0;
    bit          m_err = 0;
    logic [63:0] m_od = '0;
    logic [63:0] m_res = '0;

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            m_left = 0;
            m_ov = 0;
            m_err = 0;
            m_od = '0;
            started = 1;
        end else if (m_ov) begin
            if (out_ready) m_ov = 0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
                m_ov = 1;
                m_od = m_res;
            end
        end else if (in_valid) begin
            m_res = des_ref(in_data, key);
            m_left = 16;
            m_err = PAR_EN && key_bad(key);
        end
    end

    logic [63:0] got_q[$];
    int          got_t[$];

    always @(negedge clk) begin
        if (started) begin
            chk("in_ready", in_ready, !(m_ov || m_left > 0));
            chk("out_valid", out_valid, m_ov);
            chk("busy", busy, m_ov || m_left > 0);
            chk("key_err", key_err, m_err);
            if (m_ov) chk("out_data", out_data, m_od);
            if (out_valid && out_ready) begin
                got_q.push_back(out_data);
                got_t.push_back(cyc);
            end
        end
    end

    // ---------------- directed stimulus --------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int acc_cyc;

    task automatic send(input logic [63:0] pt, input logic [63:0] k);
        int n = 0;
        in_data = pt;
        key = k;
        in_valid = 1'b1;
        while (!in_ready && n < 100) begin
            tick();
            n++;
        end
        chk("accept_wait", n < 100, 1'b1);
        tick();
        acc_cyc = cyc;
        in_valid = 1'b0;
    endtask

    task automatic wait_out(input string nm, input logic [63:0] exp);
        int n = 0;
        while (!out_valid && n < 100) begin
            tick();
            n++;
        end
        chk({nm, "_wait"}, n < 100, 1'b1);
        chk({nm, "_latency"}, cyc - acc_cyc, 16);
        chk({nm, "_data"}, out_data, exp);
    endtask

    initial begin
        int base;
        int n;
        build_tables();

        rst = 1'b1;
        tick();
        tick();
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_key_err", key_err, 1'b0);
        chk("rst_out_data", out_data, 64'h0);
        rst = 1'b0;

        chk("model_v1", des_ref(P1, K1), C1);
        chk("model_v2", des_ref(P2, K2), C2);
        chk("model_v1_badpar", des_ref(P1, K1_BAD), C1);

        // 1, 2: plain vectors
        send(P1, K1);
        in_data = '1;
        key = '0;
        wait_out("v1", C1);
        tick();
        send(P2, K2);
        wait_out("v2", C2);
        tick();

        // 3: output back-pressure with an ignored in_valid pulse
        out_ready = 1'b0;
        send(P1, K1);
        wait_out("hold", C1);
        for (int i = 0; i < 5; i++) begin
            in_valid = (i == 2);
            in_data = P2;
            key = K2;
            tick();
            chk("hold_data", out_data, C1);
            chk("hold_valid", out_valid, 1'b1);
            chk("hold_in_ready", in_ready, 1'b0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("hold_release_valid", out_valid, 1'b0);
        chk("hold_release_ready", in_ready, 1'b1);

        // 4: reset mid-run, then a clean block
        send(P1, K1);
        repeat (7) tick();
        base = got_q.size();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_in_ready", in_ready, 1'b1);
        chk("midrst_out_valid", out_valid, 1'b0);
        chk("midrst_busy", busy, 1'b0);
        send(P2, K2);
        wait_out("after_rst", C2);
        tick();
        chk("after_rst_count", got_q.size() - base, 1);

        // 5: back-to-back streaming
        base = got_q.size();
        send(P1, K1);
        send(P2, K2);
        n = 0;
        while (got_q.size() < base + 2 && n < 100) begin
            tick();
            n++;
        end
        chk("b2b_wait", n < 100, 1'b1);
        if (got_q.size() >= base + 2) begin
            chk("b2b_first", got_q[base], C1);
            chk("b2b_second", got_q[base + 1], C2);
            chk("b2b_spacing", got_t[base + 1] - got_t[base], 18);
        end

        // 6: key parity flag
        tick();
        send(P1, K1_BAD);
        wait_out("badpar", C1);
        chk("badpar_key_err", key_err, PAR_EN);
        tick();
        send(P1, K1);
        wait_out("goodpar", C1);
        chk("goodpar_key_err", key_err, 1'b0);
        tick();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
